// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per result producer, one registered broadcast per cycle.
// Define CDB_LSB_PRIORITY_EN for fixed lowest-index-first priority instead of round-robin.
module cdb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         clear,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_id,
  input  logic [NUM_REQ*DATA_W-1:0]    req_val,
  input  logic [NUM_REQ*32-1:0]        req_pc,
  input  logic [NUM_REQ-1:0]           req_br,
  output logic                         cdb_valid,
  output logic [ROB_IDX_W-1:0]         cdb_rob_id,
  output logic [DATA_W-1:0]            cdb_val,
  output logic [31:0]                  cdb_pc,
  output logic                         cdb_br,
  output logic [$clog2(NUM_REQ)-1:0]   cdb_src
);

  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   hold_v;
  logic [ROB_IDX_W-1:0] slot_rob [NUM_REQ];
  logic [DATA_W-1:0]    slot_val [NUM_REQ];
  logic [31:0]          slot_pc  [NUM_REQ];
  logic [NUM_REQ-1:0]   slot_br;

  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     rr_next;
  logic [SRC_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [NUM_REQ-1:0]   grant;
  logic [SRC_W:0]       pos;
  logic [SRC_W-1:0]     idx;

  // Modular search from rr_ptr; pos is one bit wider so non-power-of-2 NUM_REQ wraps correctly.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (pos >= (SRC_W+1)'(NUM_REQ))
        pos = pos - (SRC_W+1)'(NUM_REQ);
      idx = pos[SRC_W-1:0];
      if (!grant_any && hold_v[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    if (grant_any)
      grant[grant_idx] = 1'b1;
  end

  assign rr_next   = (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + SRC_W'(1);
  assign req_ready = {NUM_REQ{rdy & ~rst & ~clear}} & (~hold_v | grant);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    logic                 v;
    logic                 br;
    logic [ROB_IDX_W-1:0] rob;
    logic [DATA_W-1:0]    val;
    logic [31:0]          pc;

    // Reload wins over grant-clear so a slot drained and refilled on one edge stays valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        v   <= 1'b0;
        br  <= 1'b0;
        rob <= '0;
        val <= '0;
        pc  <= '0;
      end else if (rdy) begin
        if (clear) begin
          v <= 1'b0;
        end else if (req_valid[g] && req_ready[g]) begin
          v   <= 1'b1;
          rob <= req_rob_id[g*ROB_IDX_W +: ROB_IDX_W];
          val <= req_val[g*DATA_W +: DATA_W];
          pc  <= req_pc[g*32 +: 32];
          br  <= req_br[g];
        end else if (grant[g]) begin
          v <= 1'b0;
        end
      end
    end

    assign hold_v[g]   = v;
    assign slot_br[g]  = br;
    assign slot_rob[g] = rob;
    assign slot_val[g] = val;
    assign slot_pc[g]  = pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
      cdb_pc     <= '0;
      cdb_br     <= 1'b0;
      cdb_src    <= '0;
    end else if (rdy) begin
      if (clear) begin
        cdb_valid <= 1'b0;
      end else if (grant_any) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= slot_rob[grant_idx];
        cdb_val    <= slot_val[grant_idx];
        cdb_pc     <= slot_pc[grant_idx];
        cdb_br     <= slot_br[grant_idx];
        cdb_src    <= grant_idx;
`ifdef CDB_LSB_PRIORITY_EN
        rr_ptr     <= '0;
`else
        rr_ptr     <= rr_next;
`endif
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-cycle vector table plus a saturated round-robin sequence.
module tb_cdb_arbiter;
  localparam int N  = 3;
  localparam int RW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst, rdy, clear;
  logic [N-1:0]    req_valid, req_ready, req_br;
  logic [N*RW-1:0] req_rob_id;
  logic [N*DW-1:0] req_val;
  logic [N*32-1:0] req_pc;
  logic            cdb_valid, cdb_br;
  logic [RW-1:0]   cdb_rob_id;
  logic [DW-1:0]   cdb_val;
  logic [31:0]     cdb_pc;
  logic [1:0]      cdb_src;

  cdb_arbiter #(.NUM_REQ(N), .ROB_IDX_W(RW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_rob_id(req_rob_id),
    .req_val(req_val), .req_pc(req_pc), .req_br(req_br),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .cdb_pc(cdb_pc), .cdb_br(cdb_br), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       i_rst, i_rdy, i_clr;
    logic [2:0] i_vld;
    logic [3:0] t0, t1, t2;
    logic [2:0] e_ready;
    logic       e_cv;
    logic [3:0] e_tag;
    logic [1:0] e_src;
    logic       e_zero;
  } vec_t;

  vec_t       tbl[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         row = 0;

  logic       hold_m [N];
  logic [3:0] tag_m  [N];
  logic [3:0] tnew   [N];
  logic [2:0] er;
  int         rr_m, g, ix;
  logic       exp_cv;
  logic [3:0] exp_tag;
  logic [1:0] exp_src;

  function automatic logic [31:0] fval(logic [3:0] t);
    return 32'hDEAD_BEEA + {28'd0, t};
  endfunction
  function automatic logic [31:0] fpc(logic [3:0] t);
    return 32'h0000_1000 + {26'd0, t, 2'b00};
  endfunction

  function automatic vec_t mk(int r, int y, int c, int v, int a, int b, int d,
                              int er_i, int cv, int tg, int sr, int z);
    vec_t x;
    x.i_rst = 1'(r); x.i_rdy = 1'(y); x.i_clr = 1'(c); x.i_vld = 3'(v);
    x.t0 = 4'(a); x.t1 = 4'(b); x.t2 = 4'(d);
    x.e_ready = 3'(er_i); x.e_cv = 1'(cv); x.e_tag = 4'(tg); x.e_src = 2'(sr);
    x.e_zero = 1'(z);
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic apply(logic r, logic y, logic c, logic [2:0] v,
                       logic [3:0] a, logic [3:0] b, logic [3:0] d);
    logic [3:0] t [N];
    t[0] = a; t[1] = b; t[2] = d;
    rst = r; rdy = y; clear = c; req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_rob_id[i*RW +: RW] = t[i];
      req_val[i*DW +: DW]    = fval(t[i]);
      req_pc[i*32 +: 32]     = fpc(t[i]);
      req_br[i]              = t[i][0];
    end
  endtask

  initial begin
    apply(1'b1, 1'b1, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);

    // rst, rdy, clr, vld, t0, t1, t2 | ready, cv, tag, src, zero
    tbl.push_back(mk(1,1,0,3'b000, 0, 0, 0, 3'b000,0, 0,0,1));
    tbl.push_back(mk(1,1,0,3'b000, 0, 0, 0, 3'b000,0, 0,0,1));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,0, 0,0,1));
    tbl.push_back(mk(0,1,0,3'b010, 0, 5, 0, 3'b111,0, 0,0,1));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,1, 5,1,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,0, 5,1,0));
    tbl.push_back(mk(1,1,0,3'b000, 0, 0, 0, 3'b000,0, 0,0,1));
    tbl.push_back(mk(0,1,0,3'b111, 1, 2, 3, 3'b111,0, 0,0,1));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b001,1, 1,0,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b011,1, 2,1,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,1, 3,2,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,0, 3,2,0));
    tbl.push_back(mk(0,1,0,3'b111, 4, 6,12, 3'b111,0, 3,2,0));
    tbl.push_back(mk(0,1,0,3'b010, 0, 9, 0, 3'b001,1, 4,0,0));
    tbl.push_back(mk(0,1,0,3'b010, 0, 9, 0, 3'b011,1, 6,1,0));
    tbl.push_back(mk(0,1,0,3'b010, 0,13, 0, 3'b101,1,12,2,0));
    tbl.push_back(mk(0,1,0,3'b010, 0,13, 0, 3'b111,1, 9,1,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,1,13,1,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,0,13,1,0));
    tbl.push_back(mk(0,1,0,3'b011,14,15, 0, 3'b111,0,13,1,0));
    tbl.push_back(mk(0,1,1,3'b100, 0, 0, 1, 3'b000,0,13,1,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,0,13,1,0));
    tbl.push_back(mk(0,1,0,3'b100, 0, 0, 2, 3'b111,0,13,1,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,1, 2,2,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,0, 2,2,0));
    tbl.push_back(mk(0,1,0,3'b111, 7, 8,10, 3'b111,0, 2,2,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b001,1, 7,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,3'b111, 3, 4, 5, 3'b000,1, 7,0,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b011,1, 8,1,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,1,10,2,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,0,10,2,0));
    tbl.push_back(mk(0,1,0,3'b001, 1, 0, 0, 3'b111,0,10,2,0));
    tbl.push_back(mk(0,1,0,3'b001, 2, 0, 0, 3'b111,1, 1,0,0));
    tbl.push_back(mk(0,1,0,3'b001, 3, 0, 0, 3'b111,1, 2,0,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,1, 3,0,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,0, 3,0,0));
    tbl.push_back(mk(0,1,0,3'b111, 4, 5, 6, 3'b111,0, 3,0,0));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b010,1, 5,1,0));
    tbl.push_back(mk(1,1,0,3'b000, 0, 0, 0, 3'b000,0, 0,0,1));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,0, 0,0,1));
    tbl.push_back(mk(0,1,0,3'b000, 0, 0, 0, 3'b111,0, 0,0,1));

    foreach (tbl[k]) begin
      row = k;
      @(negedge clk);
      apply(tbl[k].i_rst, tbl[k].i_rdy, tbl[k].i_clr, tbl[k].i_vld,
            tbl[k].t0, tbl[k].t1, tbl[k].t2);
      #1;
      chk("req_ready", 32'(req_ready), 32'(tbl[k].e_ready));
      @(posedge clk);
      #1;
      chk("cdb_valid",  32'(cdb_valid),  32'(tbl[k].e_cv));
      chk("cdb_rob_id", 32'(cdb_rob_id), 32'(tbl[k].e_tag));
      chk("cdb_src",    32'(cdb_src),    32'(tbl[k].e_src));
      chk("cdb_val", cdb_val, tbl[k].e_zero ? 32'd0 : fval(tbl[k].e_tag));
      chk("cdb_pc",  cdb_pc,  tbl[k].e_zero ? 32'd0 : fpc(tbl[k].e_tag));
      chk("cdb_br",  32'(cdb_br), tbl[k].e_zero ? 32'd0 : 32'(tbl[k].e_tag[0]));
    end

    // Saturated traffic: every requester refills whenever ready; grants must rotate 0,1,2.
    for (int i = 0; i < N; i++) begin
      hold_m[i] = 1'b0;
      tag_m[i]  = 4'd0;
    end
    rr_m = 0; exp_tag = 4'd0; exp_src = 2'd0; exp_cv = 1'b0;
    for (int c = 0; c < 16; c++) begin
      row = 1000 + c;
      for (int i = 0; i < N; i++) tnew[i] = 4'((c*3 + i) % 16);
      g = -1;
      for (int k = 0; k < N; k++) begin
        ix = (rr_m + k) % N;
        if (g < 0 && hold_m[ix]) g = ix;
      end
      for (int i = 0; i < N; i++) er[i] = !hold_m[i] || (g == i);
      @(negedge clk);
      apply(1'b0, 1'b1, 1'b0, (c < 12) ? 3'b111 : 3'b000, tnew[0], tnew[1], tnew[2]);
      #1;
      chk("sat_ready", 32'(req_ready), 32'(er));
      @(posedge clk);
      #1;
      if (g >= 0) begin
        exp_cv = 1'b1; exp_tag = tag_m[g]; exp_src = 2'(g);
        hold_m[g] = 1'b0;
        rr_m = (g + 1) % N;
      end else begin
        exp_cv = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && er[i]) begin
          hold_m[i] = 1'b1;
          tag_m[i]  = tnew[i];
        end
      chk("sat_valid",  32'(cdb_valid),  32'(exp_cv));
      chk("sat_rob_id", 32'(cdb_rob_id), 32'(exp_tag));
      chk("sat_src",    32'(cdb_src),    32'(exp_src));
      if (exp_cv) chk("sat_val", cdb_val, fval(exp_tag));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
